// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types for the sequential ALU: opcode encoding, FSM
//               state encoding, default datapath width and opcode decode.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOT = 4'd5,
    ALU_SHL = 4'd6,
    ALU_SHR = 4'd7,
    ALU_MUL = 4'd8
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DONE    = 2'd2
  } alu_state_t;

  // True for every opcode the ALU implements; anything above MUL is undefined.
  function automatic logic op_is_defined(input alu_op_t op);
    return (op <= ALU_MUL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_if
// Description : Request/result bundle between an ALU user (master) and the
//               sequential ALU (slave), including the status-flag feed.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH
);
  import alu_pkg::*;

  logic             alu_start;
  alu_op_t          alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_busy;
  logic             alu_done;
  logic             zero_indicator_out;
  logic             signal_bit_out;
  logic             status_wr_out;

  modport master (
    output alu_start, alu_op, alu_a, alu_b,
    input  alu_result, alu_busy, alu_done,
    input  zero_indicator_out, signal_bit_out, status_wr_out
  );

  modport slave (
    input  alu_start, alu_op, alu_a, alu_b,
    output alu_result, alu_busy, alu_done,
    output zero_indicator_out, signal_bit_out, status_wr_out
  );

endinterface
`default_nettype wire

// File: rtl/mul_shift_add.sv
`default_nettype none
// ============================================================================
// Module      : mul_shift_add
// Description : Iterative unsigned shift-add multiplier, one multiplier bit
//               per step. Keeps only the low WIDTH bits of the product.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_shift_add
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  wire logic             clock,
  input  wire logic             alu_reset,
  input  wire logic             i_load,
  input  wire logic             i_step,
  input  wire logic [WIDTH-1:0] i_a,
  input  wire logic [WIDTH-1:0] i_b,
  output logic      [WIDTH-1:0] o_product_nxt,
  output logic                  o_last
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] w_prod_step;

  // Partial product after consuming the current low multiplier bit.
  assign w_prod_step   = prod_q + (mplier_q[0] ? mcand_q : '0);
  // The owner latches this on the final step, so the product is ready on
  // the same edge that ends the run.
  assign o_product_nxt = w_prod_step;
  assign o_last        = (cnt_q == CNT_W'(WIDTH - 1));

  // Load operands or advance one bit of the shift-add recurrence.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    if (i_load) begin
      mcand_d  = i_a;
      mplier_d = i_b;
      prod_d   = '0;
      cnt_d    = '0;
    end else if (i_step) begin
      prod_d   = w_prod_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  // Multiplier state registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!alu_reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Sequential ALU. Single-cycle logic/arith ops complete in one
//               cycle; MUL runs WIDTH cycles on the shift-add sub-module.
//               Result and status flags are registered and held.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input wire logic  clock,
  input wire logic  alu_reset,
  alu_seq_if.slave  bus
);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             stw_q, stw_d;
  logic             zero_q, zero_d;
  logic             sign_q, sign_d;

  logic             w_mul_load;
  logic             w_mul_step;
  logic [WIDTH-1:0] w_mul_prod;
  logic             w_mul_last;
  logic [WIDTH-1:0] w_alu_val;

  mul_shift_add #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clock         (clock),
    .alu_reset     (alu_reset),
    .i_load        (w_mul_load),
    .i_step        (w_mul_step),
    .i_a           (bus.alu_a),
    .i_b           (bus.alu_b),
    .o_product_nxt (w_mul_prod),
    .o_last        (w_mul_last)
  );

  // Single-cycle datapath; undefined opcodes (and MUL here) yield zero.
  always_comb begin
    w_alu_val = '0;
    case (bus.alu_op)
      ALU_ADD: w_alu_val = bus.alu_a + bus.alu_b;
      ALU_SUB: w_alu_val = bus.alu_a - bus.alu_b;
      ALU_AND: w_alu_val = bus.alu_a & bus.alu_b;
      ALU_OR:  w_alu_val = bus.alu_a | bus.alu_b;
      ALU_XOR: w_alu_val = bus.alu_a ^ bus.alu_b;
      ALU_NOT: w_alu_val = ~bus.alu_a;
      ALU_SHL: w_alu_val = bus.alu_a << 1;
      ALU_SHR: w_alu_val = bus.alu_a >> 1;
      default: w_alu_val = '0;
    endcase
  end

  // Next-state and registered-output logic; start is honoured only in IDLE.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    stw_d      = 1'b0;
    zero_d     = zero_q;
    sign_d     = sign_q;
    w_mul_load = 1'b0;
    w_mul_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.alu_start) begin
          busy_d = 1'b1;
          if (bus.alu_op == ALU_MUL) begin
            state_d    = ST_MUL_RUN;
            w_mul_load = 1'b1;
          end else begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = w_alu_val;
            // Undefined opcodes complete but leave the status flags alone.
            if (op_is_defined(bus.alu_op)) begin
              stw_d  = 1'b1;
              zero_d = (w_alu_val == '0);
              sign_d = w_alu_val[WIDTH-1];
            end
          end
        end
      end
      ST_MUL_RUN: begin
        w_mul_step = 1'b1;
        if (w_mul_last) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          stw_d    = 1'b1;
          result_d = w_mul_prod;
          zero_d   = (w_mul_prod == '0);
          sign_d   = w_mul_prod[WIDTH-1];
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM and output registers; reset wins over any start in the same cycle.
  always_ff @(posedge clock) begin
    if (!alu_reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stw_q    <= 1'b0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      stw_q    <= stw_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
    end
  end

  assign bus.alu_result         = result_q;
  assign bus.alu_busy           = busy_q;
  assign bus.alu_done           = done_q;
  assign bus.status_wr_out      = stw_q;
  assign bus.zero_indicator_out = zero_q;
  assign bus.signal_bit_out     = sign_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed self-checking bench for alu_seq (WIDTH = 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
  import alu_pkg::*;

  localparam int WIDTH = 16;

  logic clock;
  logic alu_reset;
  int   n_checks;
  int   n_fail;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .alu_reset (alu_reset),
    .bus       (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a one-cycle start; returns in the first cycle after acceptance.
  task automatic start_op(input alu_op_t op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.alu_start = 1'b1;
    bus.alu_op    = op;
    bus.alu_a     = a;
    bus.alu_b     = b;
    tick();
    bus.alu_start = 1'b0;
  endtask

  // Single-cycle op: done/strobe in cycle 1, flags follow result, then idle.
  task automatic run_single(input string tag, input alu_op_t op, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp);
    start_op(op, a, b);
    check_eq({tag, "_result"}, 32'(bus.alu_result), 32'(exp));
    check_eq({tag, "_done"}, 32'(bus.alu_done), 32'd1);
    check_eq({tag, "_stw"}, 32'(bus.status_wr_out), 32'd1);
    check_eq({tag, "_busy"}, 32'(bus.alu_busy), 32'd1);
    check_eq({tag, "_z"}, 32'(bus.zero_indicator_out), 32'(exp == '0));
    check_eq({tag, "_n"}, 32'(bus.signal_bit_out), 32'(exp[WIDTH-1]));
    tick();
    check_eq({tag, "_done_off"}, 32'(bus.alu_done), 32'd0);
    check_eq({tag, "_stw_off"}, 32'(bus.status_wr_out), 32'd0);
    check_eq({tag, "_busy_off"}, 32'(bus.alu_busy), 32'd0);
    check_eq({tag, "_hold"}, 32'(bus.alu_result), 32'(exp));
  endtask

  initial begin
    int cyc;
    int pulses;
    n_checks      = 0;
    n_fail        = 0;
    alu_reset     = 1'b0;
    bus.alu_start = 1'b0;
    bus.alu_op    = ALU_ADD;
    bus.alu_a     = '0;
    bus.alu_b     = '0;
    repeat (3) tick();
    alu_reset = 1'b1;

    // Reset state
    check_eq("rst_result", 32'(bus.alu_result), 32'd0);
    check_eq("rst_busy", 32'(bus.alu_busy), 32'd0);
    check_eq("rst_done", 32'(bus.alu_done), 32'd0);
    check_eq("rst_stw", 32'(bus.status_wr_out), 32'd0);
    check_eq("rst_z", 32'(bus.zero_indicator_out), 32'd0);
    check_eq("rst_n", 32'(bus.signal_bit_out), 32'd0);
    tick();

    // Single-cycle ops with hand-computed results
    run_single("add", ALU_ADD, 16'h7FFF, 16'h0001, 16'h8000);
    run_single("sub", ALU_SUB, 16'h1234, 16'h1234, 16'h0000);
    run_single("and", ALU_AND, 16'hF0F0, 16'h3C3C, 16'h3030);
    run_single("or",  ALU_OR,  16'hF0F0, 16'h3C3C, 16'hFCFC);
    run_single("xor", ALU_XOR, 16'hF0F0, 16'h3C3C, 16'hCCCC);
    run_single("not", ALU_NOT, 16'h00FF, 16'h1234, 16'hFF00);
    run_single("shl", ALU_SHL, 16'h8001, 16'h0000, 16'h0002);
    run_single("shr", ALU_SHR, 16'h8001, 16'h0000, 16'h4000);
    run_single("addwrap", ALU_ADD, 16'hFFFF, 16'h0002, 16'h0001);

    // Reset takes priority over a simultaneous start
    alu_reset = 1'b0;
    start_op(ALU_ADD, 16'h0003, 16'h0004);
    alu_reset = 1'b1;
    check_eq("rstpri_busy", 32'(bus.alu_busy), 32'd0);
    check_eq("rstpri_done", 32'(bus.alu_done), 32'd0);
    check_eq("rstpri_result", 32'(bus.alu_result), 32'd0);
    tick();
    check_eq("rstpri_busy2", 32'(bus.alu_busy), 32'd0);

    // Establish N=1/Z=0, then an undefined opcode must keep those flags
    run_single("sub_neg", ALU_SUB, 16'h0005, 16'h0006, 16'hFFFF);
    start_op(alu_op_t'(4'hF), 16'h0001, 16'h0001);
    check_eq("undef_done", 32'(bus.alu_done), 32'd1);
    check_eq("undef_result", 32'(bus.alu_result), 32'd0);
    check_eq("undef_stw", 32'(bus.status_wr_out), 32'd0);
    check_eq("undef_z", 32'(bus.zero_indicator_out), 32'd0);
    check_eq("undef_n", 32'(bus.signal_bit_out), 32'd1);
    tick();
    check_eq("undef_done_off", 32'(bus.alu_done), 32'd0);
    check_eq("undef_stw_off", 32'(bus.status_wr_out), 32'd0);

    // MUL 0x12*0x34: busy 16 run cycles, a start mid-run ignored, operands perturbed
    start_op(ALU_MUL, 16'h0012, 16'h0034);
    for (int c = 1; c <= 16; c++) begin
      check_eq("mul_busy", 32'(bus.alu_busy), 32'd1);
      check_eq("mul_nodone", 32'(bus.alu_done), 32'd0);
      if (c == 3) begin
        bus.alu_start = 1'b1;
        bus.alu_op    = ALU_ADD;
        bus.alu_a     = 16'h0001;
        bus.alu_b     = 16'h0001;
      end else begin
        bus.alu_start = 1'b0;
        bus.alu_a     = 16'hAAAA;
        bus.alu_b     = 16'h5555;
      end
      tick();
    end
    check_eq("mul_done", 32'(bus.alu_done), 32'd1);
    check_eq("mul_busy17", 32'(bus.alu_busy), 32'd1);
    check_eq("mul_stw", 32'(bus.status_wr_out), 32'd1);
    check_eq("mul_result", 32'(bus.alu_result), 32'h03A8);
    check_eq("mul_z", 32'(bus.zero_indicator_out), 32'd0);
    check_eq("mul_n", 32'(bus.signal_bit_out), 32'd0);
    // Start during DONE must be dropped
    start_op(ALU_ADD, 16'h0002, 16'h0002);
    check_eq("donestart_busy", 32'(bus.alu_busy), 32'd0);
    check_eq("donestart_done", 32'(bus.alu_done), 32'd0);
    check_eq("donestart_hold", 32'(bus.alu_result), 32'h03A8);
    tick();
    check_eq("donestart_busy2", 32'(bus.alu_busy), 32'd0);
    check_eq("donestart_done2", 32'(bus.alu_done), 32'd0);

    // MUL truncation with bounded wait for done
    start_op(ALU_MUL, 16'hFFFF, 16'h0002);
    cyc = 1;
    while (!bus.alu_done && cyc < 40) begin
      tick();
      cyc++;
    end
    check_eq("mul2_latency", 32'(cyc), 32'd17);
    check_eq("mul2_result", 32'(bus.alu_result), 32'hFFFE);
    check_eq("mul2_n", 32'(bus.signal_bit_out), 32'd1);
    check_eq("mul2_z", 32'(bus.zero_indicator_out), 32'd0);
    tick();

    // Reset in cycle 5 of a multiply aborts it with no completion pulse
    start_op(ALU_MUL, 16'h0003, 16'h0005);
    repeat (4) tick();
    alu_reset = 1'b0;
    tick();
    alu_reset = 1'b1;
    check_eq("abort_busy", 32'(bus.alu_busy), 32'd0);
    check_eq("abort_done", 32'(bus.alu_done), 32'd0);
    check_eq("abort_stw", 32'(bus.status_wr_out), 32'd0);
    check_eq("abort_result", 32'(bus.alu_result), 32'd0);
    check_eq("abort_z", 32'(bus.zero_indicator_out), 32'd0);
    check_eq("abort_n", 32'(bus.signal_bit_out), 32'd0);
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (bus.alu_done || bus.status_wr_out || bus.alu_busy) pulses++;
    end
    check_eq("abort_no_activity", 32'(pulses), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
